// File: rtl/ttl_register_file_if.sv
// ---------------------------------------------------------------------------
// ttl_register_file_if
//
// Purpose: groups the write port, read port, output-enable and error
// handshake of ttl_register_file into one bundle. The CPU-side logic (or
// the bench) takes the master view and the register file takes the slave
// view.
//
// Parameters:
//   WIDTH : data width in bits
//   DEPTH : number of words in the attached register file
//   AW    : address width, derived from DEPTH
//
// Signals:
//   we, waddr, wdata  : synchronous write port
//   re, raddr         : registered read port (loads the output latch)
//   oe_n              : active-low output enable for the three-state bus
//   err_clr           : clears the sticky error flag
//   rvalid            : high for the one cycle after an accepted read
//   err               : sticky error flag
//
// The three-state data bus q is kept as a plain port on the register file
// so that the bus driver sits directly on the block boundary.
// ---------------------------------------------------------------------------
interface ttl_register_file_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   localparam int AW = $clog2(DEPTH);

   logic             we;
   logic [AW-1:0]    waddr;
   logic [WIDTH-1:0] wdata;
   logic             re;
   logic [AW-1:0]    raddr;
   logic             oe_n;
   logic             err_clr;
   logic             rvalid;
   logic             err;

   // Bus owner: drives the accesses and watches the status flags.
   modport master (
      output we, waddr, wdata, re, raddr, oe_n, err_clr,
      input  rvalid, err
   );

   // Register file: receives the accesses and reports status.
   modport slave (
      input  we, waddr, wdata, re, raddr, oe_n, err_clr,
      output rvalid, err
   );
endinterface

// File: rtl/ttl_register_file.sv
// ---------------------------------------------------------------------------
// ttl_register_file
//
// Purpose: DEPTH x WIDTH register file replacing banks of discrete octal
// edge-triggered registers. One synchronous write port, one registered read
// port that loads an output latch, and a three-state output bus driven from
// that latch. Each word carries a "written" bit so reads of words that were
// never written since reset are flagged.
//
// Ports:
//   clk  : sole clock, all state changes on its rising edge
//   rst  : synchronous active-high reset, priority over every access
//   bus  : ttl_register_file_if.slave (we/waddr/wdata, re/raddr, oe_n,
//          err_clr in; rvalid, err out)
//   q    : three-state output, latch value when oe_n=0, all-Z otherwise
//
// Configuration macro: TTL_REGFILE_BYPASS_EN
//   defined   : a read and a write to the same in-range address in the same
//               cycle return wdata, and the word counts as written
//   undefined : the same collision returns the old word (read-before-write),
//               as the discrete chips did
// ---------------------------------------------------------------------------
module ttl_register_file #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   ttl_register_file_if.slave      bus,
   output logic [WIDTH-1:0]        q
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0] written_q;
   logic [DEPTH-1:0] written_d;
   logic [WIDTH-1:0] latch_q;
   logic [WIDTH-1:0] latch_d;
   logic             rvalid_q;
   logic             rvalid_d;
   logic             err_q;
   logic             err_d;

   logic             wrInRange;
   logic             rdInRange;
   logic             errEvent;

   // DEPTH need not be a power of two, so both addresses are range-checked
   // against DEPTH rather than trusting the address width.
   assign wrInRange = (int'(bus.waddr) < DEPTH);
   assign rdInRange = (int'(bus.raddr) < DEPTH);

   // Next-state logic for storage, written bits, the output latch and the
   // status flags. The read always looks at the pre-edge storage; the only
   // exception is the write-through path when the bypass build is selected.
   // Any error raised this cycle beats an err_clr in the same cycle.
   always_comb begin
      mem_d     = mem_q;
      written_d = written_q;
      latch_d   = latch_q;
      rvalid_d  = 1'b0;
      errEvent  = 1'b0;

      if (bus.we) begin
         if (wrInRange) begin
            mem_d[bus.waddr]     = bus.wdata;
            written_d[bus.waddr] = 1'b1;
         end else begin
            errEvent = 1'b1;
         end
      end

      if (bus.re) begin
         rvalid_d = 1'b1;
         if (!rdInRange) begin
            latch_d  = '0;
            errEvent = 1'b1;
         end
`ifdef TTL_REGFILE_BYPASS_EN
         else if (bus.we && (bus.waddr == bus.raddr)) begin
            latch_d = bus.wdata;
         end
`endif
         else if (!written_q[bus.raddr]) begin
            latch_d  = '0;
            errEvent = 1'b1;
         end else begin
            latch_d = mem_q[bus.raddr];
         end
      end

      err_d = errEvent | (err_q & ~bus.err_clr);
   end

   // State registers. Reset clears everything, including an access that
   // was being presented in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         written_q <= '0;
         latch_q   <= '0;
         rvalid_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         mem_q     <= mem_d;
         written_q <= written_d;
         latch_q   <= latch_d;
         rvalid_q  <= rvalid_d;
         err_q     <= err_d;
      end
   end

   // Output enable acts on the bus driver only, never on stored state.
   assign q          = bus.oe_n ? {WIDTH{1'bz}} : latch_q;
   assign bus.rvalid = rvalid_q;
   assign bus.err    = err_q;

endmodule

// File: tb/tb_ttl_register_file.sv
// ---------------------------------------------------------------------------
// tb_ttl_register_file
//
// Drives one directed vector stream into two register files at once: an
// 8x4 instance and an 8x3 instance, so the same addresses exercise both the
// in-range and the out-of-range rules. A behavioural model of each file
// predicts q, rvalid and err every cycle, and literal expectations at key
// points pin both the model and the design.
// ---------------------------------------------------------------------------
module tb_ttl_register_file;

   logic       clk = 1'b0;
   logic       rst;
   logic       we;
   logic [1:0] waddr;
   logic [7:0] wdata;
   logic       re;
   logic [1:0] raddr;
   logic       oeN;
   logic       errClr;

   wire  [7:0] q4;
   wire  [7:0] q3;

   int         errors  = 0;
   int         checks  = 0;
   bit         started = 1'b0;

   logic [7:0] zVal = 8'hzz;

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   ttl_register_file_if #(.WIDTH(8), .DEPTH(4)) bus4 ();
   ttl_register_file_if #(.WIDTH(8), .DEPTH(3)) bus3 ();

   assign bus4.we      = we;
   assign bus4.waddr   = waddr;
   assign bus4.wdata   = wdata;
   assign bus4.re      = re;
   assign bus4.raddr   = raddr;
   assign bus4.oe_n    = oeN;
   assign bus4.err_clr = errClr;

   assign bus3.we      = we;
   assign bus3.waddr   = waddr;
   assign bus3.wdata   = wdata;
   assign bus3.re      = re;
   assign bus3.raddr   = raddr;
   assign bus3.oe_n    = oeN;
   assign bus3.err_clr = errClr;

   ttl_register_file #(.WIDTH(8), .DEPTH(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4.slave),
      .q   (q4)
   );

   ttl_register_file #(.WIDTH(8), .DEPTH(3)) dut3 (
      .clk (clk),
      .rst (rst),
      .bus (bus3.slave),
      .q   (q3)
   );

   // Behavioural model, index 0 = depth 4, index 1 = depth 3.
   logic [7:0] mMem     [2][4];
   bit         mWritten [2][4];
   logic [7:0] mLatch   [2];
   bit         mRvalid  [2];
   bit         mErr     [2];

   function automatic int depthOf(input int d);
      return (d == 0) ? 4 : 3;
   endfunction

   // Model update at each rising edge from the inputs presented that cycle.
   always @(posedge clk) begin
      bit errNow;
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            for (int a = 0; a < 4; a++) begin
               mMem[d][a]     = 8'h00;
               mWritten[d][a] = 1'b0;
            end
            mLatch[d]  = 8'h00;
            mRvalid[d] = 1'b0;
            mErr[d]    = 1'b0;
         end else begin
            errNow     = 1'b0;
            mRvalid[d] = re;
            if (re) begin
               if (int'(raddr) >= depthOf(d)) begin
                  mLatch[d] = 8'h00;
                  errNow    = 1'b1;
               end
`ifdef TTL_REGFILE_BYPASS_EN
               else if (we && waddr == raddr) begin
                  mLatch[d] = wdata;
               end
`endif
               else if (!mWritten[d][raddr]) begin
                  mLatch[d] = 8'h00;
                  errNow    = 1'b1;
               end else begin
                  mLatch[d] = mMem[d][raddr];
               end
            end
            if (we) begin
               if (int'(waddr) < depthOf(d)) begin
                  mMem[d][waddr]     = wdata;
                  mWritten[d][waddr] = 1'b1;
               end else begin
                  errNow = 1'b1;
               end
            end
            mErr[d] = errNow || (mErr[d] && !errClr);
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual,
                  expected, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the rising edge.
   always @(negedge clk) begin
      if (started) begin
         checkOutput("dut4.q", {24'h0, q4}, {24'h0, (oeN ? zVal : mLatch[0])});
         checkOutput("dut4.rvalid", {31'h0, bus4.rvalid}, {31'h0, mRvalid[0]});
         checkOutput("dut4.err", {31'h0, bus4.err}, {31'h0, mErr[0]});
         checkOutput("dut3.q", {24'h0, q3}, {24'h0, (oeN ? zVal : mLatch[1])});
         checkOutput("dut3.rvalid", {31'h0, bus3.rvalid}, {31'h0, mRvalid[1]});
         checkOutput("dut3.err", {31'h0, bus3.err}, {31'h0, mErr[1]});
      end
   end

   // Presents one vector for exactly one rising edge, returning shortly
   // after that edge so literal checks see the updated outputs.
   task automatic applyStimulus(input logic r, input logic w,
                                input logic [1:0] wa, input logic [7:0] wd,
                                input logic rd, input logic [1:0] ra,
                                input logic oe, input logic clr);
      rst    = r;
      we     = w;
      waddr  = wa;
      wdata  = wd;
      re     = rd;
      raddr  = ra;
      oeN    = oe;
      errClr = clr;
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst = 1'b1; we = 1'b0; waddr = 2'd0; wdata = 8'h00;
      re = 1'b0; raddr = 2'd0; oeN = 1'b0; errClr = 1'b0;

      // Reset state with the bus enabled.
      applyStimulus(1, 0, 0, 8'h00, 0, 0, 0, 0);
      started = 1'b1;
      checkOutput("reset q", {24'h0, q4}, 32'h00);
      checkOutput("reset rvalid", {31'h0, bus4.rvalid}, 32'h0);
      checkOutput("reset err", {31'h0, bus4.err}, 32'h0);

      // Bus disabled after reset.
      applyStimulus(0, 0, 0, 8'h00, 0, 0, 1, 0);
      checkOutput("reset q hiz", {24'h0, q4}, {24'h0, zVal});

      // Write then read back, rvalid for one cycle, latch holds.
      applyStimulus(0, 1, 2, 8'hA5, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 8'h00, 1, 2, 0, 0);
      checkOutput("read2 q", {24'h0, q4}, 32'hA5);
      checkOutput("read2 rvalid", {31'h0, bus4.rvalid}, 32'h1);
      checkOutput("model latch", {24'h0, mLatch[0]}, 32'hA5);
      applyStimulus(0, 0, 0, 8'h00, 0, 0, 0, 0);
      checkOutput("rvalid one cycle", {31'h0, bus4.rvalid}, 32'h0);
      applyStimulus(0, 0, 0, 8'h00, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 8'h00, 0, 0, 0, 0);
      checkOutput("hold q", {24'h0, q4}, 32'hA5);
      applyStimulus(0, 0, 0, 8'h00, 0, 0, 1, 0);
      checkOutput("hiz with data", {24'h0, q4}, {24'h0, zVal});

      // Unwritten read, clear, clear colliding with a new error.
      applyStimulus(0, 0, 0, 8'h00, 1, 1, 0, 0);
      checkOutput("unwritten q", {24'h0, q4}, 32'h00);
      checkOutput("unwritten err", {31'h0, bus4.err}, 32'h1);
      applyStimulus(0, 0, 0, 8'h00, 0, 0, 0, 1);
      checkOutput("err_clr", {31'h0, bus4.err}, 32'h0);
      applyStimulus(0, 0, 0, 8'h00, 1, 3, 0, 1);
      checkOutput("clr vs new err", {31'h0, bus4.err}, 32'h1);
      checkOutput("model err", {31'h0, mErr[0]}, 32'h1);
      applyStimulus(0, 0, 0, 8'h00, 0, 0, 0, 1);

      // Address 3 is in range for depth 4, out of range for depth 3.
      applyStimulus(0, 1, 3, 8'h77, 0, 0, 0, 0);
      checkOutput("d3 write oor err", {31'h0, bus3.err}, 32'h1);
      checkOutput("d4 write3 err", {31'h0, bus4.err}, 32'h0);
      applyStimulus(0, 0, 0, 8'h00, 1, 3, 0, 0);
      checkOutput("d3 read oor q", {24'h0, q3}, 32'h00);
      checkOutput("d3 read oor rvalid", {31'h0, bus3.rvalid}, 32'h1);
      checkOutput("d3 read oor err", {31'h0, bus3.err}, 32'h1);
      checkOutput("d4 read3 q", {24'h0, q4}, 32'h77);
      applyStimulus(0, 0, 0, 8'h00, 0, 0, 0, 1);

      // Same-cycle write and read of a written word.
      applyStimulus(0, 1, 0, 8'h11, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 8'h3C, 1, 0, 0, 0);
`ifdef TTL_REGFILE_BYPASS_EN
      checkOutput("collide q", {24'h0, q4}, 32'h3C);
`else
      checkOutput("collide q", {24'h0, q4}, 32'h11);
`endif
      checkOutput("collide err", {31'h0, bus4.err}, 32'h0);
      applyStimulus(0, 0, 0, 8'h00, 1, 0, 0, 0);
      checkOutput("after collide q", {24'h0, q4}, 32'h3C);

      // Same-cycle write and read of an unwritten word.
      applyStimulus(0, 1, 1, 8'h5A, 1, 1, 0, 0);
`ifdef TTL_REGFILE_BYPASS_EN
      checkOutput("collide new q", {24'h0, q4}, 32'h5A);
      checkOutput("collide new err", {31'h0, bus4.err}, 32'h0);
`else
      checkOutput("collide new q", {24'h0, q4}, 32'h00);
      checkOutput("collide new err", {31'h0, bus4.err}, 32'h1);
`endif

      // Reset beats a write and a read presented in the same cycle.
      applyStimulus(1, 1, 0, 8'hFF, 1, 0, 0, 0);
      checkOutput("rst q", {24'h0, q4}, 32'h00);
      checkOutput("rst rvalid", {31'h0, bus4.rvalid}, 32'h0);
      checkOutput("rst err", {31'h0, bus4.err}, 32'h0);
      applyStimulus(0, 0, 0, 8'h00, 1, 0, 0, 0);
      checkOutput("post rst q", {24'h0, q4}, 32'h00);
      checkOutput("post rst err", {31'h0, bus4.err}, 32'h1);

      // Back-to-back reads with independent writes to other addresses.
      applyStimulus(0, 1, 1, 8'h21, 0, 0, 0, 1);
      applyStimulus(0, 1, 2, 8'h42, 1, 1, 0, 0);
      applyStimulus(0, 1, 0, 8'h63, 1, 2, 0, 0);
      checkOutput("b2b q", {24'h0, q4}, 32'h42);
      applyStimulus(0, 0, 0, 8'h00, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 8'h00, 1, 1, 0, 0);
      checkOutput("b2b last q", {24'h0, q4}, 32'h21);
      checkOutput("b2b rvalid", {31'h0, bus4.rvalid}, 32'h1);
      checkOutput("b2b err", {31'h0, bus4.err}, 32'h0);
      applyStimulus(0, 0, 0, 8'h00, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 8'h00, 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
